// File: rtl/pce_audio_pkg.sv
// Shared widths, constants and the I2S slot-bit helper for the PCE audio
// serializer.
package pce_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int PHASE_W    = 24;

    // 6.144 MHz SCLK toggle rate from 42.954545 MHz -> 48 kHz LRCK.
    localparam logic [PHASE_W-1:0] PHASE_INC_DEFAULT = 24'd2399727;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Philips I2S slot: one idle bit, 16 data bits MSB first, then zero padding.
    function automatic logic slot_bit(input sample_t word, input logic [4:0] slot);
        logic [4:0] idx;
        logic       res;
        idx = 5'd16 - slot;
        res = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            res = word[idx[3:0]];
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_nco_tick.sv
// Fractional phase accumulator; the registered carry-out marks each SCLK
// half-period.
module audio_nco_tick
    import pce_audio_pkg::*;
#(
    parameter int                 PHASE_W   = 24,
    parameter logic [PHASE_W-1:0] PHASE_INC = PHASE_INC_DEFAULT
) (
    input  logic clk_sys_42_95,
    input  logic reset_n,
    output logic tick
);

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W:0]   phase_sum;

    assign phase_sum = {1'b0, phase_reg} + {1'b0, PHASE_INC};

    always_ff @(posedge clk_sys_42_95 or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= '0;
            tick      <= 1'b0;
        end else begin
            phase_reg <= phase_sum[PHASE_W-1:0];
            tick      <= phase_sum[PHASE_W];
        end
    end

endmodule

// File: rtl/pce_audio_i2s_tx.sv
// I2S transmitter for the PCE mixer output: NCO-derived SCLK/LRCK, optional
// box-car averaging, frame-atomic L/R load with mute.
module pce_audio_i2s_tx
    import pce_audio_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_INC = PHASE_INC_DEFAULT,
    parameter int                 AVG_LOG2  = 9
) (
    input  logic                       clk_sys_42_95,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] audio_l,
    input  logic signed [SAMPLE_W-1:0] audio_r,
    input  logic                       mute,
    output logic                       i2s_sclk,
    output logic                       i2s_lrck,
    output logic                       i2s_sdata,
    output logic                       sample_strobe
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;

    logic                 tick;
    logic                 sclk_reg;
    logic                 lrck_reg;
    logic                 sdata_reg;
    logic                 strobe_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_next;
    sample_t              tx_l_reg;
    sample_t              tx_r_reg;
    sample_t              pending_l_reg;
    sample_t              pending_r_reg;
    sample_t              word;
    logic                 fall;
    logic                 frame_load;
    logic                 win_wrap;
    sample_t              in_ch    [2];
    sample_t              avg_next [2];

    audio_nco_tick #(
        .PHASE_W   (PHASE_W),
        .PHASE_INC (PHASE_INC)
    ) u_nco (
        .clk_sys_42_95 (clk_sys_42_95),
        .reset_n       (reset_n),
        .tick          (tick)
    );

    assign in_ch[0] = audio_l;
    assign in_ch[1] = audio_r;

    generate
        if (AVG_LOG2 == 0) begin : g_hold
            assign win_wrap = 1'b1;
            for (genvar gi = 0; gi < 2; gi++) begin : g_ch
                assign avg_next[gi] = in_ch[gi];
            end
        end else begin : g_avg
            logic [AVG_LOG2-1:0] win_cnt_reg;

            assign win_wrap = &win_cnt_reg;

            always_ff @(posedge clk_sys_42_95 or negedge reset_n) begin
                if (!reset_n) begin
                    win_cnt_reg <= '0;
                end else begin
                    win_cnt_reg <= win_cnt_reg + 1'b1;
                end
            end

            for (genvar gi = 0; gi < 2; gi++) begin : g_ch
                logic signed [ACC_W-1:0] acc_reg;
                logic signed [ACC_W-1:0] acc_sum;

                // Sum of 2^AVG_LOG2 samples always fits ACC_W; >>> floors.
                assign acc_sum      = acc_reg + ACC_W'(in_ch[gi]);
                assign avg_next[gi] = sample_t'(acc_sum >>> AVG_LOG2);

                always_ff @(posedge clk_sys_42_95 or negedge reset_n) begin
                    if (!reset_n) begin
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= win_wrap ? '0 : acc_sum;
                    end
                end
            end
        end
    endgenerate

    assign fall         = tick & sclk_reg;
    assign bit_cnt_next = bit_cnt_reg + 1'b1;
    assign frame_load   = fall && (bit_cnt_reg == BIT_CNT_W'(FRAME_BITS - 1));
    assign word         = bit_cnt_next[BIT_CNT_W-1] ? tx_r_reg : tx_l_reg;

    always_ff @(posedge clk_sys_42_95 or negedge reset_n) begin
        if (!reset_n) begin
            sclk_reg      <= 1'b0;
            lrck_reg      <= 1'b0;
            sdata_reg     <= 1'b0;
            strobe_reg    <= 1'b0;
            bit_cnt_reg   <= BIT_CNT_W'(FRAME_BITS - 1);
            tx_l_reg      <= '0;
            tx_r_reg      <= '0;
            pending_l_reg <= '0;
            pending_r_reg <= '0;
        end else begin
            strobe_reg <= frame_load;
            if (tick) begin
                sclk_reg <= ~sclk_reg;
            end
            if (fall) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= bit_cnt_next[BIT_CNT_W-1];
                sdata_reg   <= slot_bit(word, bit_cnt_next[4:0]);
            end
            // Non-blocking update: a coincident window wrap is seen next frame.
            if (frame_load) begin
                tx_l_reg <= mute ? '0 : pending_l_reg;
                tx_r_reg <= mute ? '0 : pending_r_reg;
            end
            if (win_wrap) begin
                pending_l_reg <= avg_next[0];
                pending_r_reg <= avg_next[1];
            end
        end
    end

    assign i2s_sclk      = sclk_reg;
    assign i2s_lrck      = lrck_reg;
    assign i2s_sdata     = sdata_reg;
    assign sample_strobe = strobe_reg;

endmodule

// File: tb/tb_pce_audio_i2s_tx.sv
// Directed bench: dut_a runs the default NCO with sample-and-hold, dut_b a fast
// NCO with a 4-clock averaging window.
module tb_pce_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mute_a = 1'b0;
    logic        mute_b = 1'b0;
    logic [15:0] a_l = 16'h8001;
    logic [15:0] a_r = 16'h7FFE;
    logic [15:0] b_l = 16'h1000;
    logic [15:0] b_r = 16'hFFFE;
    logic        sel = 1'b0;

    logic a_sclk, a_lrck, a_sdata, a_strobe;
    logic b_sclk, b_lrck, b_sdata, b_strobe;
    logic m_sclk, m_lrck, m_sdata, m_strobe;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pce_audio_i2s_tx #(
        .AVG_LOG2 (0)
    ) dut_a (
        .clk_sys_42_95 (clk),
        .reset_n       (reset_n),
        .audio_l       (a_l),
        .audio_r       (a_r),
        .mute          (mute_a),
        .i2s_sclk      (a_sclk),
        .i2s_lrck      (a_lrck),
        .i2s_sdata     (a_sdata),
        .sample_strobe (a_strobe)
    );

    pce_audio_i2s_tx #(
        .PHASE_INC (24'h800000),
        .AVG_LOG2  (2)
    ) dut_b (
        .clk_sys_42_95 (clk),
        .reset_n       (reset_n),
        .audio_l       (b_l),
        .audio_r       (b_r),
        .mute          (mute_b),
        .i2s_sclk      (b_sclk),
        .i2s_lrck      (b_lrck),
        .i2s_sdata     (b_sdata),
        .sample_strobe (b_strobe)
    );

    assign m_sclk   = sel ? b_sclk   : a_sclk;
    assign m_lrck   = sel ? b_lrck   : a_lrck;
    assign m_sdata  = sel ? b_sdata  : a_sdata;
    assign m_strobe = sel ? b_strobe : a_strobe;

    // dut_b inputs alternate every clock.
    always @(negedge clk) begin
        b_l = (b_l == 16'h1000) ? 16'h3000 : 16'h1000;
        b_r = (b_r == 16'hFFFE) ? 16'hFFFD : 16'hFFFE;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
    endfunction

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (m_strobe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Captures the frame loaded at the next strobe: sdata/lrck at each SCLK rise.
    task automatic capture(input int mute_rise, input logic mute_val,
                           output logic [63:0] bits, output logic [63:0] lr,
                           output int unstable, output bit ok);
        logic prev_sclk, prev_sdata;
        int   k;
        bits = '0;
        lr = '0;
        unstable = 0;
        k = 0;
        wait_strobe(ok);
        if (ok) begin
            prev_sclk  = m_sclk;
            prev_sdata = m_sdata;
            for (int c = 0; c < 4000 && k < 64; c++) begin
                @(negedge clk);
                if (!prev_sclk && m_sclk) begin
                    bits[63-k] = m_sdata;
                    lr[63-k]   = m_lrck;
                    if (m_sdata !== prev_sdata) unstable++;
                    if (k == mute_rise) begin
                        if (sel) mute_b = mute_val;
                        else     mute_a = mute_val;
                    end
                    k++;
                end
                prev_sclk  = m_sclk;
                prev_sdata = m_sdata;
            end
            ok = (k == 64);
        end
    endtask

    // After reset release the first strobe must coincide with the first SCLK fall.
    task automatic first_fall_check(input string tag);
        logic prev_sclk;
        bit   found;
        int   early;
        prev_sclk = m_sclk;
        found = 1'b0;
        early = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (prev_sclk && !m_sclk) begin
                found = 1'b1;
                chk({tag, "_strobe_at_fall"}, 64'(m_strobe), 64'd1);
                chk({tag, "_lrck_at_fall"}, 64'(m_lrck), 64'd0);
                break;
            end
            if (m_strobe) early++;
            prev_sclk = m_sclk;
        end
        chk({tag, "_fall_seen"}, 64'(found), 64'd1);
        chk({tag, "_early_strobe"}, 64'(early), 64'd0);
    endtask

    initial begin
        logic [63:0] bits, lr;
        int          unstable, cyc, rises, lr_rises, strobes, bad, falls;
        bit          ok;
        logic        prev_sclk, prev_lrck, prev_strobe;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_a_outputs", 64'({a_sclk, a_lrck, a_sdata, a_strobe}), 64'd0);
        chk("reset_b_outputs", 64'({b_sclk, b_lrck, b_sdata, b_strobe}), 64'd0);
        reset_n = 1'b1;

        // Sample-and-hold serialization of 8001/7FFE
        sel = 1'b0;
        first_fall_check("a_init");
        capture(-1, 1'b0, bits, lr, unstable, ok);
        chk("a_cap_done", 64'(ok), 64'd1);
        chk("a_frame_8001_7ffe", bits, frame(16'h8001, 16'h7FFE));
        chk("a_lrck_pattern", lr, 64'h00000000_FFFFFFFF);
        chk("a_sdata_stable_at_rise", 64'(unstable), 64'd0);

        // LRCK period over 20 frames, 64 SCLK per LRCK
        ok = 1'b0;
        prev_lrck = m_lrck;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!prev_lrck && m_lrck) begin ok = 1'b1; break; end
            prev_lrck = m_lrck;
        end
        chk("a_lrck_rise_seen", 64'(ok), 64'd1);
        cyc = 0; rises = 0; lr_rises = 0;
        prev_lrck = m_lrck;
        prev_sclk = m_sclk;
        while (lr_rises < 20 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!prev_sclk && m_sclk) rises++;
            if (!prev_lrck && m_lrck) lr_rises++;
            prev_sclk = m_sclk;
            prev_lrck = m_lrck;
        end
        checks++;
        assert (cyc >= 17896 && cyc <= 17899) else begin
            failures++;
            $error("FAIL lrck_period_20 observed=%0d expected=17896..17899", cyc);
        end
        $display("check lrck_period_20 observed=%0d expected=17896..17899", cyc);
        chk("sclk_rises_20_frames", 64'(rises), 64'd1280);

        // Averaging on dut_b
        sel = 1'b1;
        wait_strobe(ok);
        chk("b_flush_strobe", 64'(ok), 64'd1);
        capture(-1, 1'b0, bits, lr, unstable, ok);
        chk("b_cap_done", 64'(ok), 64'd1);
        chk("b_frame_avg_2000_fffd", bits, frame(16'h2000, 16'hFFFD));
        chk("b_lrck_pattern", lr, 64'h00000000_FFFFFFFF);

        // 100 frames: one single-cycle strobe per LRCK 1->0
        wait_strobe(ok);
        strobes = 0; bad = 0; falls = 0; cyc = 0;
        prev_lrck = m_lrck;
        prev_strobe = m_strobe;
        while (falls < 100 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (prev_lrck && !m_lrck) falls++;
            if (m_strobe) begin
                strobes++;
                if (!(prev_lrck && !m_lrck)) bad++;
                if (prev_strobe) bad++;
            end
            prev_lrck = m_lrck;
            prev_strobe = m_strobe;
        end
        chk("b_strobe_count_100", 64'(strobes), 64'd100);
        chk("b_strobe_misaligned", 64'(bad), 64'd0);

        // Mute mid left slot on dut_a
        sel = 1'b0;
        a_l = 16'h1234;
        a_r = 16'h0055;
        wait_strobe(ok);
        capture(8, 1'b1, bits, lr, unstable, ok);
        chk("mute_frame_in_flight", bits, frame(16'h1234, 16'h0055));
        capture(-1, 1'b0, bits, lr, unstable, ok);
        chk("mute_frame_zero", bits, 64'd0);
        capture(8, 1'b0, bits, lr, unstable, ok);
        chk("unmute_frame_still_zero", bits, 64'd0);
        capture(-1, 1'b0, bits, lr, unstable, ok);
        chk("unmute_resume", bits, frame(16'h1234, 16'h0055));
        chk("mute_cap_done", 64'(ok), 64'd1);

        // Asynchronous reset mid right slot
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (a_lrck && a_sclk) begin ok = 1'b1; break; end
        end
        chk("right_slot_reached", 64'(ok), 64'd1);
        #1 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 64'({a_sclk, a_lrck, a_sdata, a_strobe}), 64'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        first_fall_check("a_rerelease");
        capture(-1, 1'b0, bits, lr, unstable, ok);
        chk("post_reset_frame", bits, frame(16'h1234, 16'h0055));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
